ex_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit that sits beside the combinational EX ALU. It executes MULT/MULTU/DIV/DIVU over multiple cycles into architectural HI/LO registers and services MTHI/MTLO writes. It raises busy so the pipeline can stall EX until the result is committed. HI/LO are exposed to EX for MFHI/MFLO.

---
 rtl/ex_muldiv_pkg.sv | 24 ++
 rtl/ex_muldiv_div_step.sv | 31 +++
 rtl/ex_muldiv.sv | 193 +++++++++++++++++++
 tb/tb_ex_muldiv.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared op codes, FSM state encoding and helpers for the
// iterative multiply/divide unit.
package ex_muldiv_pkg;

    localparam logic [1:0] MULDIV_OP_MULT  = 2'b00;
    localparam logic [1:0] MULDIV_OP_MULTU = 2'b01;
    localparam logic [1:0] MULDIV_OP_DIV   = 2'b10;
    localparam logic [1:0] MULDIV_OP_DIVU  = 2'b11;

    typedef logic [1:0] muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } muldiv_state_e;

    // op[0]=0 selects the signed variant (MULT/DIV).
    function automatic logic op_is_signed(input muldiv_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/ex_muldiv_div_step.sv
// ex_muldiv_div_step: one combinational restoring-division step.
// Ports:
//   rem_i     - partial remainder before the step (always < divisor)
//   bit_i     - next dividend bit, MSB first
//   divisor_i - divisor magnitude
//   rem_o     - partial remainder after the step
//   q_o       - quotient bit produced by the step
module ex_muldiv_div_step
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic                  bit_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic                  q_o
);
    // The shifted remainder needs one extra bit before the trial subtract.
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] rem_full;
    logic                unused_rem_msb;

    assign shifted  = {rem_i, bit_i};
    assign q_o      = (shifted >= {1'b0, divisor_i});
    assign rem_full = q_o ? (shifted - {1'b0, divisor_i}) : shifted;
    // After a step the remainder is again below the divisor, so the MSB is 0.
    assign rem_o          = rem_full[DATA_WIDTH-1:0];
    assign unused_rem_msb = rem_full[DATA_WIDTH];

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle W x W multiply,
// IDLE -> FIX directly for MULT/MULTU).
// Ports:
//   clk, rst          - clock, async active-high reset
//   flush             - abort in-flight MUL/DIV (FIX still commits)
//   start, op         - request an operation (sampled in IDLE only)
//   operand_1/2       - rs/rt values
//   hi/lo_write_en    - MTHI/MTLO strobes (IDLE only), with hi/lo_write_data
//   busy              - unit not idle (stall request)
//   done              - one-cycle pulse while the result is being committed
//   hi, lo            - HI/LO registers
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_1,
    input  logic [DATA_WIDTH-1:0] operand_2,
    input  logic                  hi_write_en,
    input  logic                  lo_write_en,
    input  logic [DATA_WIDTH-1:0] hi_write_data,
    input  logic [DATA_WIDTH-1:0] lo_write_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

    muldiv_state_e   state_q, state_d;
    logic [W-1:0]    a_q, a_d;        // multiplicand magnitude
    logic [W-1:0]    b_q, b_d;        // divisor magnitude
    logic [2*W-1:0]  acc_q, acc_d;    // {partial product, remaining multiplier}
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;    // dividend bits shift out, quotient bits in
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic            sgnq_q, sgnq_d;
    logic            sgnr_q, sgnr_d;
    logic            dv_q, dv_d;      // result in FIX comes from the divider
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    logic            s1, s2;
    logic [W-1:0]    op1_abs, op2_abs;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    step_rem;
    logic            step_q;

    assign s1      = op_is_signed(op) & operand_1[W-1];
    assign s2      = op_is_signed(op) & operand_2[W-1];
    assign op1_abs = s1 ? -operand_1 : operand_1;
    assign op2_abs = s2 ? -operand_2 : operand_2;

    // Shift-add: add multiplicand into the upper half when the multiplier
    // LSB (acc[0]) is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign prod_fix = sgnq_q ? -acc_q : acc_q;

    ex_muldiv_div_step #(.DATA_WIDTH(W)) u_div_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[W-1]),
        .divisor_i (b_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        dv_d    = dv_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (hi_write_en) hi_d = hi_write_data;
                if (lo_write_en) lo_d = lo_write_data;
                if (start && !flush) begin
                    a_d    = op1_abs;
                    b_d    = op2_abs;
                    sgnq_d = s1 ^ s2;
                    sgnr_d = s1;
                    cnt_d  = '0;
                    dv_d   = op[1];
                    if (op[1]) begin
                        rem_d   = '0;
                        quo_d   = op1_abs;
                        state_d = ST_DIV;
                        // Divide by zero: preload the fixed result and let
                        // FIX commit it unsigned.
                        if (operand_2 == '0) begin
                            rem_d   = operand_1;
                            quo_d   = '1;
                            sgnq_d  = 1'b0;
                            sgnr_d  = 1'b0;
                            state_d = ST_FIX;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        acc_d   = {{W{1'b0}}, op1_abs} * {{W{1'b0}}, op2_abs};
                        state_d = ST_FIX;
`else
                        acc_d   = {{W{1'b0}}, op2_abs};
                        state_d = ST_MUL;
`endif
                    end
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == LAST) state_d = ST_FIX;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = {quo_q[W-2:0], step_q};
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == LAST) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // Commit happens regardless of flush.
                if (dv_q) begin
                    lo_d = sgnq_q ? -quo_q : quo_q;
                    hi_d = sgnr_q ? -rem_q : rem_q;
                end else begin
                    hi_d = prod_fix[2*W-1:W];
                    lo_d = prod_fix[W-1:0];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            dv_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            dv_q    <= dv_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_FIX);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed + random self-checking bench for ex_muldiv.
// Expected results come from 64-bit arithmetic on the operands.
module tb_ex_muldiv;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0, start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  operand_1 = '0, operand_2 = '0;
    logic          hi_write_en = 1'b0, lo_write_en = 1'b0;
    logic [W-1:0]  hi_write_data = '0, lo_write_data = '0;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int n_assert = 0;
    int n_fail   = 0;

    ex_muldiv #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
        .operand_1(operand_1), .operand_2(operand_2),
        .hi_write_en(hi_write_en), .lo_write_en(lo_write_en),
        .hi_write_data(hi_write_data), .lo_write_data(lo_write_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Architectural result {HI, LO} of an operation.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MULT:  res = 64'(sa * sb);
            MULTU: res = {32'b0, a} * {32'b0, b};
            DIV: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] e;
        int lat, busy_cnt, exp_lat;
        e = model(o, a, b);
        exp_lat = o[1] ? ((b == 0) ? 1 : W + 1) : MUL_LAT;
        @(negedge clk);
        op = o; operand_1 = a; operand_2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_cnt = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1) busy_cnt++;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
        @(negedge clk);
        check({tag, " done/busy after"}, {62'b0, done, busy}, 64'b0);
        check({tag, " hi:lo"}, {hi, lo}, e);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int done_cnt;

        #12;
        check("reset busy/done", {62'b0, busy, done}, 64'b0);
        check("reset hi:lo", {hi, lo}, 64'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");
        run_op(MULT,  32'hFFFF_FFFD, 32'd7,         "mult -3*7");
        run_op(MULT,  32'd6,         32'd7,         "mult 6*7");
        run_op(DIV,   32'hFFFF_FFF9, 32'd2,         "div -7/2");
        run_op(DIVU,  32'd100,       32'd7,         "divu 100/7");
        run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
        run_op(DIVU,  32'd5,         32'd0,         "divu by zero");
        run_op(DIV,   32'hFFFF_FFF0, 32'd0,         "div neg by zero");

        // MTHI/MTLO in IDLE.
        @(negedge clk);
        hi_write_en = 1'b1; hi_write_data = 32'h11;
        lo_write_en = 1'b1; lo_write_data = 32'h22;
        @(negedge clk);
        hi_write_en = 1'b0; lo_write_en = 1'b0;
        check("mthi/mtlo", {hi, lo}, {32'h11, 32'h22});

        // flush beats start in IDLE.
        start = 1'b1; flush = 1'b1; op = MULTU; operand_1 = 32'd9; operand_2 = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush over start", {63'b0, busy}, 64'b0);

        // Flush mid-operation; a start and an MTHI while busy are ignored.
        op = MULTU;
`ifdef MULDIV_FAST_MUL_EN
        op = DIVU;
`endif
        operand_1 = 32'd3; operand_2 = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = MULTU; operand_1 = 32'd5; operand_2 = 32'd5;
        hi_write_en = 1'b1; hi_write_data = 32'h99;
        @(negedge clk);
        start = 1'b0; hi_write_en = 1'b0;
        repeat (4) @(negedge clk);
        check("busy before flush", {63'b0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("busy after flush", {63'b0, busy}, 64'b0);
        done_cnt = 0;
        repeat (40) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("no done after flush", 64'(done_cnt), 64'd0);
        check("hi:lo kept after flush", {hi, lo}, {32'h11, 32'h22});

        // Random operations, occasionally with a zero or tiny divisor.
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, "random");
        end

        // Async reset mid-DIV clears everything immediately.
        run_op(DIVU, 32'd100, 32'd7, "divu before reset");
        @(negedge clk);
        op = DIV; operand_1 = 32'h1234_5678; operand_2 = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("busy mid-div", {63'b0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async reset busy/done", {62'b0, busy, done}, 64'b0);
        check("async reset hi:lo", {hi, lo}, 64'b0);
        @(negedge clk);
        rst = 1'b0;
        run_op(MULT, 32'h8000_0000, 32'h8000_0000, "mult min*min after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
